// File: rtl/cpc_bus_sequencer.sv
// CPC CPU bus-cycle sequencer. It owns the master phase counter and the CRTC/PSG
// clock enables. It generates Z80 WAIT_n, decodes NUM_IO I/O channels, each with its
// own extra-wait count, and combines their read data as an open-drain AND.
// Optional feature: define RESYNC_EN to add the resync input. A registered rising
// edge on resync forces the phase back to zero.
module cpc_bus_sequencer #(
    parameter int unsigned PHASES     = 4,
    parameter int unsigned CRTC_PHASE = 0,
    parameter int unsigned PSG_PHASE  = 0,
    parameter int unsigned NUM_IO     = 4,
    parameter int unsigned XW_W       = 3,
    localparam int unsigned PH_W      = $clog2(PHASES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_4p,
    input  logic                     ce_4n,
    input  logic                     no_wait,
`ifdef RESYNC_EN
    input  logic                     resync,
`endif
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     m1_n,
    input  logic [15:0]              addr,
    input  logic [NUM_IO*16-1:0]     io_base,
    input  logic [NUM_IO*16-1:0]     io_mask,
    input  logic [NUM_IO*XW_W-1:0]   io_xwait,
    input  logic [NUM_IO*8-1:0]      io_rdata,
    output logic [PH_W-1:0]          phase,
    output logic                     ce_crtc,
    output logic                     ce_psg,
    output logic                     wait_n,
    output logic [NUM_IO-1:0]        io_sel,
    output logic                     io_rd,
    output logic                     io_wr,
    output logic                     intack,
    output logic [7:0]               bus_din
);

    typedef enum logic [1:0] {StIdle, StAlign, StXwait, StDone} state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [XW_W-1:0]   cnt_q, cnt_d;
    logic [XW_W-1:0]   xw;
    logic              req;
    logic              align_evt;
    logic              phase_wrap;

`ifdef RESYNC_EN
    logic              resync_q;
    logic              rise_q;
`endif

    assign req        = ~mreq_n | ~iorq_n;
    assign io_rd      = ~(rd_n | iorq_n);
    assign io_wr      = ~(wr_n | iorq_n);
    assign intack     = ~(m1_n | iorq_n);
    assign phase      = phase_q;
    assign phase_wrap = ce_4p & (phase_q == PH_W'(PHASES - 1));
    assign ce_crtc    = ce_4p & (phase_q == PH_W'(CRTC_PHASE));
    // ce_4p wins if both enables are ever high together.
    assign ce_psg     = ce_4n & ~ce_4p & (phase_q == PH_W'(PSG_PHASE));

`ifdef RESYNC_EN
    assign align_evt  = phase_wrap | rise_q;
`else
    assign align_evt  = phase_wrap;
`endif

    // Channel address decode; several channels may match at once.
    always_comb begin
        io_sel = '0;
        for (int i = 0; i < int'(NUM_IO); i++) begin
            io_sel[i] = ~iorq_n & m1_n &
                        ((addr & io_mask[16*i +: 16]) == (io_base[16*i +: 16] & io_mask[16*i +: 16]));
        end
    end

    // Extra-wait count from the lowest-index selected channel (descending scan, last hit wins).
    always_comb begin
        xw = '0;
        for (int i = int'(NUM_IO) - 1; i >= 0; i--) begin
            if (io_sel[i]) xw = io_xwait[XW_W*i +: XW_W];
        end
    end

    // Open-drain read-data combine over selected channels.
    always_comb begin
        bus_din = 8'hFF;
        if (io_rd) begin
            for (int i = 0; i < int'(NUM_IO); i++) begin
                if (io_sel[i]) bus_din = bus_din & io_rdata[8*i +: 8];
            end
        end
    end

    // Phase counter next state; resync (if built) overrides ce_4p.
    always_comb begin
        phase_d = phase_q;
        if (phase_wrap)  phase_d = '0;
        else if (ce_4p)  phase_d = phase_q + PH_W'(1);
`ifdef RESYNC_EN
        if (rise_q)      phase_d = '0;
`endif
    end

    // WAIT FSM next state and wait_n output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_n  = 1'b1;
        case (state_q)
            StIdle: begin
                wait_n = ~req | ((phase_q == '0) & (xw == '0));
                if (req) begin
                    if (phase_q != '0) begin
                        state_d = StAlign;
                    end else if (xw != '0) begin
                        state_d = StXwait;
                        cnt_d   = xw;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAlign: begin
                wait_n = 1'b0;
                if (!req) begin
                    state_d = StIdle;
                end else if (align_evt) begin
                    if (xw == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StXwait;
                        cnt_d   = xw;
                    end
                end
            end
            StXwait: begin
                wait_n = 1'b0;
                if (!req) begin
                    state_d = StIdle;
                end else if (ce_4p) begin
                    cnt_d = cnt_q - XW_W'(1);
                    if (cnt_q == XW_W'(1)) state_d = StDone;
                end
            end
            StDone: begin
                if (!req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Turbo mode overrides every state.
        if (no_wait) begin
            wait_n  = 1'b1;
            state_d = StDone;
        end
    end

    // State, phase and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            cnt_q    <= '0;
`ifdef RESYNC_EN
            resync_q <= 1'b0;
            rise_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
`ifdef RESYNC_EN
            resync_q <= resync;
            rise_q   <= resync & ~resync_q;
`endif
        end
    end

endmodule

// File: tb/tb_cpc_bus_sequencer.sv
// Self-checking bench for cpc_bus_sequencer: a cycle model of the bus rules plus
// directed scenarios with literal expectations.
module tb_cpc_bus_sequencer;

    localparam int PHASES = 4;
    localparam int NUM_IO = 4;
    localparam int XW_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset, ce_4p, ce_4n, no_wait;
    logic                   mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [15:0]            addr;
    logic [NUM_IO*16-1:0]   io_base, io_mask;
    logic [NUM_IO*XW_W-1:0] io_xwait;
    logic [NUM_IO*8-1:0]    io_rdata;
    logic [1:0]             phase;
    logic                   ce_crtc, ce_psg, wait_n, io_rd, io_wr, intack;
    logic [NUM_IO-1:0]      io_sel;
    logic [7:0]             bus_din;
`ifdef RESYNC_EN
    logic                   resync = 1'b0;
`endif

    cpc_bus_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .ce_4p    (ce_4p),
        .ce_4n    (ce_4n),
        .no_wait  (no_wait),
`ifdef RESYNC_EN
        .resync   (resync),
`endif
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .m1_n     (m1_n),
        .addr     (addr),
        .io_base  (io_base),
        .io_mask  (io_mask),
        .io_xwait (io_xwait),
        .io_rdata (io_rdata),
        .phase    (phase),
        .ce_crtc  (ce_crtc),
        .ce_psg   (ce_psg),
        .wait_n   (wait_n),
        .io_sel   (io_sel),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .intack   (intack),
        .bus_din  (bus_din)
    );

    int nvec = 0;
    int nerr = 0;
    int crtc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: phase as a plain count, and a request as "ce_4p ticks still owed".
    bit model_on = 1'b0;
    int m_phase  = 0;
    bit m_active = 1'b0;
    bit m_served = 1'b0;
    int m_rem    = 0;

    always @(negedge clk) begin
        logic [NUM_IO-1:0] s;
        logic [7:0]        d;
        int                x;
        int                rem0;
        bit                req, ew, found;
        if (model_on) begin
            found = 1'b0;
            x = 0;
            for (int i = 0; i < NUM_IO; i++) begin
                s[i] = !iorq_n && m1_n &&
                       ((addr & io_mask[16*i +: 16]) == (io_base[16*i +: 16] & io_mask[16*i +: 16]));
                if (s[i] && !found) begin
                    found = 1'b1;
                    x = int'(io_xwait[XW_W*i +: XW_W]);
                end
            end
            d = 8'hFF;
            if (!rd_n && !iorq_n)
                for (int i = 0; i < NUM_IO; i++) if (s[i]) d = d & io_rdata[8*i +: 8];
            req  = !mreq_n || !iorq_n;
            rem0 = ((PHASES - m_phase) % PHASES) + x;
            if (no_wait)                 ew = 1'b1;
            else if (m_active)           ew = 1'b0;
            else if (!req || m_served)   ew = 1'b1;
            else                         ew = (rem0 == 0);

            chk("m_phase",   32'(phase),   32'(m_phase));
            chk("m_ce_crtc", 32'(ce_crtc), 32'(ce_4p && m_phase == 0));
            chk("m_ce_psg",  32'(ce_psg),  32'(ce_4n && !ce_4p && m_phase == 0));
            chk("m_wait_n",  32'(wait_n),  32'(ew));
            chk("m_io_sel",  32'(io_sel),  32'(s));
            chk("m_io_rd",   32'(io_rd),   32'(!rd_n && !iorq_n));
            chk("m_io_wr",   32'(io_wr),   32'(!wr_n && !iorq_n));
            chk("m_intack",  32'(intack),  32'(!m1_n && !iorq_n));
            chk("m_bus_din", 32'(bus_din), 32'(d));

            if (reset) begin
                m_phase  = 0;
                m_active = 1'b0;
                m_served = 1'b0;
            end else begin
                if (ce_4p) m_phase = (m_phase + 1) % PHASES;
                if (no_wait) begin
                    m_served = 1'b1;
                    m_active = 1'b0;
                end else if (!req) begin
                    m_active = 1'b0;
                    m_served = 1'b0;
                end else if (m_served) begin
                    m_served = 1'b1;
                end else if (m_active) begin
                    if (ce_4p) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_active = 1'b0;
                            m_served = 1'b1;
                        end
                    end
                end else begin
                    // Requests never start on a ce_4p cycle in this bench.
                    m_rem = rem0;
                    if (rem0 == 0) m_served = 1'b1;
                    else           m_active = 1'b1;
                end
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // One T-state: a ce_4p clock followed by a quiet clock.
    task automatic t4p();
        ce_4p = 1'b1;
        #1;
        if (ce_crtc === 1'b1) crtc_cnt++;
        clk1();
        ce_4p = 1'b0;
        clk1();
    endtask

    task automatic count_wait(output int n);
        n = 0;
        while (wait_n === 1'b0 && n < 16) begin
            t4p();
            n++;
        end
    endtask

    task automatic set_ch(input int i, input logic [15:0] b, input logic [15:0] m,
                          input logic [XW_W-1:0] xw, input logic [7:0] rd);
        io_base[16*i +: 16]    = b;
        io_mask[16*i +: 16]    = m;
        io_xwait[XW_W*i +: XW_W] = xw;
        io_rdata[8*i +: 8]     = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; ce_4p = 1'b0; ce_4n = 1'b0; no_wait = 1'b0;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        addr = 16'h0000;
        io_base = '0; io_mask = '0; io_xwait = '0; io_rdata = '0;
        set_ch(0, 16'h0000, 16'hFFFF, 3'd0, 8'h11);
        set_ch(1, 16'hF400, 16'h0800, 3'd2, 8'h22);
        set_ch(2, 16'h1234, 16'hFFFF, 3'd0, 8'h33);
        set_ch(3, 16'h5678, 16'hFFFF, 3'd0, 8'h44);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_on = 1'b1;

        // Reset state and free-running phase.
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_wait_n", 32'(wait_n), 32'd1);
        for (int k = 0; k < 12; k++) begin
            t4p();
            chk("t1_phase", 32'(phase), 32'((k + 1) % 4));
        end
        chk("t1_crtc_pulses", 32'(crtc_cnt), 32'd3);
        ce_4n = 1'b1;
        #1;
        chk("t1_ce_psg", 32'(ce_psg), 32'd1);
        ce_4p = 1'b1;
        #1;
        chk("t1_psg_prio", 32'(ce_psg), 32'd0);
        ce_4p = 1'b0;
        ce_4n = 1'b0;
        clk1();

        // Memory read starting at phase 1: three T-states of alignment.
        t4p();
        mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("t2_wait_first", 32'(wait_n), 32'd0);
        clk1();
        count_wait(n);
        chk("t2_wait_ticks", 32'(n), 32'd3);
        chk("t2_phase_at_rise", 32'(phase), 32'd0);
        mreq_n = 1'b1; rd_n = 1'b1;
        clk1();

        // I/O read on channel 1 at phase 0: two extra T-states.
        addr = 16'hF512; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("t3_io_sel", 32'(io_sel), 32'b0010);
        chk("t3_wait_first", 32'(wait_n), 32'd0);
        clk1();
        count_wait(n);
        chk("t3_wait_ticks", 32'(n), 32'd2);
        iorq_n = 1'b1; rd_n = 1'b1;
        clk1();

        // Two channels selected: open-drain AND of F0 and 3C.
        set_ch(0, 16'h7F00, 16'h8000, 3'd0, 8'hF0);
        set_ch(2, 16'h0000, 16'h8000, 3'd0, 8'h3C);
        set_ch(3, 16'h5678, 16'hFFFF, 3'd0, 8'hAA);
        addr = 16'h7F10; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk("t4_io_sel", 32'(io_sel), 32'b0101);
        chk("t4_bus_din", 32'(bus_din), 32'h30);
        rd_n = 1'b1;
        #1;
        chk("t4_bus_din_idle", 32'(bus_din), 32'hFF);
        wr_n = 1'b0;
        clk1();
        wr_n = 1'b1; iorq_n = 1'b1;
        clk1();
        m1_n = 1'b0; iorq_n = 1'b0;
        #1;
        chk("t4_intack", 32'(intack), 32'd1);
        chk("t4_intack_sel", 32'(io_sel), 32'd0);
        clk1();
        m1_n = 1'b1; iorq_n = 1'b1;
        clk1();

        // Turbo mode, then reset in the middle of an aligning cycle.
        no_wait = 1'b1;
        t4p();
        t4p();
        mreq_n = 1'b0;
        #1;
        chk("t5_nowait", 32'(wait_n), 32'd1);
        clk1();
        t4p();
        chk("t5_nowait_held", 32'(wait_n), 32'd1);
        mreq_n = 1'b1;
        clk1();
        no_wait = 1'b0;
        clk1();
        n = 0;
        while (phase !== 2'd2 && n < 8) begin
            t4p();
            n++;
        end
        mreq_n = 1'b0; rd_n = 1'b0;
        clk1();
        chk("t5_align_wait", 32'(wait_n), 32'd0);
        t4p();
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        chk("t5_rst_phase", 32'(phase), 32'd0);
        chk("t5_rst_wait", 32'(wait_n), 32'd1);
        mreq_n = 1'b1; rd_n = 1'b1;
        clk1();

        // Abort while aligning: ALIGN still holds WAIT for one clock, then IDLE.
        t4p();
        mreq_n = 1'b0;
        clk1();
        t4p();
        mreq_n = 1'b1;
        #1;
        chk("t5_abort_align", 32'(wait_n), 32'd0);
        clk1();
        chk("t5_abort_idle", 32'(wait_n), 32'd1);
        clk1();

`ifdef RESYNC_EN
        // Resync rising at phase 2 during ALIGN: phase 0 and WAIT released two clocks later.
        n = 0;
        while (phase !== 2'd2 && n < 8) begin
            t4p();
            n++;
        end
        mreq_n = 1'b0;
        clk1();
        model_on = 1'b0;
        resync = 1'b1;
        clk1();
        chk("t6_phase_hold", 32'(phase), 32'd2);
        chk("t6_wait_hold", 32'(wait_n), 32'd0);
        clk1();
        chk("t6_phase_zero", 32'(phase), 32'd0);
        chk("t6_wait_rise", 32'(wait_n), 32'd1);
        resync = 1'b0;
        mreq_n = 1'b1;
        clk1();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
